// File: rtl/risc_control_unit_pkg.sv
// Shared encodings for the RISC processing unit: opcodes, FSM states, bus-mux
// selects and instruction field positions.
package risc_control_unit_pkg;

    localparam int word_size  = 8;
    localparam int op_size    = 4;
    localparam int Sel1_size  = 3;
    localparam int Sel2_size  = 2;
    localparam int state_size = 4;

    // Instruction layout: [7:4] opcode, [3:2] src register, [1:0] dest register
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 4;
    localparam int SRC_MSB  = 3;
    localparam int SRC_LSB  = 2;
    localparam int DEST_MSB = 1;
    localparam int DEST_LSB = 0;

    typedef enum logic [op_size-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_NOT = 4'd4,
        OP_RD  = 4'd5,
        OP_WR  = 4'd6,
        OP_BR  = 4'd7,
        OP_BRZ = 4'd8
    } opcode_t;

    typedef enum logic [state_size-1:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [Sel1_size-1:0] SEL1_R0 = 3'd0;
    localparam logic [Sel1_size-1:0] SEL1_R1 = 3'd1;
    localparam logic [Sel1_size-1:0] SEL1_R2 = 3'd2;
    localparam logic [Sel1_size-1:0] SEL1_R3 = 3'd3;
    localparam logic [Sel1_size-1:0] SEL1_PC = 3'd4;

    localparam logic [Sel2_size-1:0] SEL2_ALU  = 2'd0;
    localparam logic [Sel2_size-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [Sel2_size-1:0] SEL2_MEM  = 2'd2;

    // Register-file index to one-hot load vector {R3, R2, R1, R0}
    function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/risc_control_unit.sv
// Multi-cycle control FSM for the RISC processing unit: fetch, decode, then
// execute/memory/branch states, with a combinational strobe decoder.
module risc_control_unit
    import risc_control_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 Zflag,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted
);

    state_t            state;
    logic [op_size-1:0] opcode;
    logic [1:0]         src;
    logic [1:0]         dest;
    logic [3:0]         load_r;

    assign opcode = instruction[OP_MSB:OP_LSB];
    assign src    = instruction[SRC_MSB:SRC_LSB];
    assign dest   = instruction[DEST_MSB:DEST_LSB];

    // NOTE: state is updated with non-blocking assignments so every reader sees
    // the pre-edge value; blocking here would create simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_idle;
        end else begin
            case (state)
                S_idle: state <= S_fet1;
                S_fet1: state <= S_fet2;
                S_fet2: state <= S_dec;
                S_dec: begin
                    case (opcode)
                        OP_NOP:                state <= S_fet1;
                        OP_ADD, OP_SUB, OP_AND: state <= S_ex1;
                        OP_NOT:                state <= S_fet1;
                        OP_RD:                 state <= S_rd1;
                        OP_WR:                 state <= S_wr1;
                        OP_BR:                 state <= S_br1;
                        OP_BRZ:                state <= Zflag ? S_br1 : S_fet1;
                        default:               state <= S_halt;
                    endcase
                end
                S_ex1:  state <= S_fet1;
                S_rd1:  state <= S_rd2;
                S_rd2:  state <= S_fet1;
                S_wr1:  state <= S_wr2;
                S_wr2:  state <= S_fet1;
                S_br1:  state <= S_br2;
                S_br2:  state <= S_fet1;
                S_halt: state <= S_halt;
                default: state <= S_halt;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        load_r        = 4'b0000;
        Load_PC       = 1'b0;
        Inc_PC        = 1'b0;
        Sel_Bus_1_Mux = SEL1_R0;
        Sel_Bus_2_Mux = SEL2_ALU;
        Load_IR       = 1'b0;
        Load_Add_R    = 1'b0;
        Load_Reg_Y    = 1'b0;
        Load_Reg_Z    = 1'b0;
        write         = 1'b0;

        case (state)
            S_fet1: begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = SEL2_BUS1;
                Load_Add_R    = 1'b1;
            end
            S_fet2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_IR       = 1'b1;
                Inc_PC        = 1'b1;
            end
            S_dec: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        Sel_Bus_1_Mux = {1'b0, src};
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Reg_Y    = 1'b1;
                    end
                    OP_NOT: begin
                        Sel_Bus_1_Mux = {1'b0, src};
                        Sel_Bus_2_Mux = SEL2_ALU;
                        Load_Reg_Z    = 1'b1;
                        load_r        = reg_onehot(dest);
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        Sel_Bus_1_Mux = SEL1_PC;
                        Sel_Bus_2_Mux = SEL2_BUS1;
                        Load_Add_R    = 1'b1;
                    end
                    OP_BRZ: begin
                        // Not taken: step PC over the branch-target operand byte
                        if (Zflag) begin
                            Sel_Bus_1_Mux = SEL1_PC;
                            Sel_Bus_2_Mux = SEL2_BUS1;
                            Load_Add_R    = 1'b1;
                        end else begin
                            Inc_PC = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_ex1: begin
                Sel_Bus_1_Mux = {1'b0, dest};
                Sel_Bus_2_Mux = SEL2_ALU;
                Load_Reg_Z    = 1'b1;
                load_r        = reg_onehot(dest);
            end
            S_rd1, S_wr1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
                Inc_PC        = 1'b1;
            end
            S_rd2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                load_r        = reg_onehot(dest);
            end
            S_wr2: begin
                Sel_Bus_1_Mux = {1'b0, src};
                write         = 1'b1;
            end
            S_br1: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_Add_R    = 1'b1;
            end
            S_br2: begin
                Sel_Bus_2_Mux = SEL2_MEM;
                Load_PC       = 1'b1;
            end
            default: ;
        endcase
    end

    assign {Load_R3, Load_R2, Load_R1, Load_R0} = load_r;
    assign halted = (state == S_halt);

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: stimulus queues per-cycle expected
// strobe vectors, a monitor pops and compares them against the DUT outputs.
module tb_risc_control_unit;

    logic       clk;
    logic       rst;
    logic [7:0] instruction;
    logic       Zflag;
    logic       Load_R0, Load_R1, Load_R2, Load_R3;
    logic       Load_PC, Inc_PC;
    logic [2:0] Sel_Bus_1_Mux;
    logic [1:0] Sel_Bus_2_Mux;
    logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
    logic       write, halted;

    typedef struct packed {
        logic [3:0] load_r;
        logic       load_pc;
        logic       inc_pc;
        logic [2:0] sel1;
        logic [1:0] sel2;
        logic       load_ir;
        logic       load_add_r;
        logic       load_reg_y;
        logic       load_reg_z;
        logic       wr;
        logic       halted;
    } outs_t;

    typedef struct {
        string name;
        outs_t exp;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    outs_t act;

    risc_control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .Zflag         (Zflag),
        .Load_R0       (Load_R0),
        .Load_R1       (Load_R1),
        .Load_R2       (Load_R2),
        .Load_R3       (Load_R3),
        .Load_PC       (Load_PC),
        .Inc_PC        (Inc_PC),
        .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
        .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
        .Load_IR       (Load_IR),
        .Load_Add_R    (Load_Add_R),
        .Load_Reg_Y    (Load_Reg_Y),
        .Load_Reg_Z    (Load_Reg_Z),
        .write         (write),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        act = '0;
        act.load_r     = {Load_R3, Load_R2, Load_R1, Load_R0};
        act.load_pc    = Load_PC;
        act.inc_pc     = Inc_PC;
        act.sel1       = Sel_Bus_1_Mux;
        act.sel2       = Sel_Bus_2_Mux;
        act.load_ir    = Load_IR;
        act.load_add_r = Load_Add_R;
        act.load_reg_y = Load_Reg_Y;
        act.load_reg_z = Load_Reg_Z;
        act.wr         = write;
        act.halted     = halted;
    end

    // Monitor: samples mid-cycle (and just after an async reset assertion)
    initial begin
        item_t it;
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check(it.name, act, it.exp);
            end
        end
    end

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (load_r,pc,inc,sel1,sel2,ir,ar,y,z,wr,halt)",
                     name, got, exp);
        end
    endtask

    function automatic outs_t mk(input logic [3:0] lr, input logic lpc, input logic inc,
                                 input logic [2:0] s1, input logic [1:0] s2,
                                 input logic ir, input logic ar, input logic y,
                                 input logic z, input logic wr, input logic h);
        outs_t o;
        o = {lr, lpc, inc, s1, s2, ir, ar, y, z, wr, h};
        return o;
    endfunction

    // Hand-derived expected vectors
    localparam outs_t E_ZERO = '0;
    outs_t e_fet1, e_fet2, e_pc_addr, e_mem_addr_inc, e_halt;

    task automatic expect_cycle(input string name, input outs_t e);
        item_t it;
        it.name = name;
        it.exp  = e;
        exp_q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [7:0] instr);
        expect_cycle({tag, "_fet1"}, e_fet1);
        instruction = instr;
        expect_cycle({tag, "_fet2"}, e_fet2);
    endtask

    initial begin
        item_t it;
        e_fet1         = mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        e_fet2         = mk(4'b0000, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
        e_pc_addr      = mk(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        e_mem_addr_inc = mk(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
        e_halt         = mk(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1);

        rst = 1'b1;
        instruction = 8'h00;
        Zflag = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) expect_cycle("reset_held", E_ZERO);
        rst = 1'b0;
        expect_cycle("idle_after_reset", E_ZERO);

        // ADD src=R3 dest=R2
        fetch("add", 8'h1E);
        expect_cycle("add_dec", mk(4'b0000, 0, 0, 3'd3, 2'd1, 0, 0, 1, 0, 0, 0));
        expect_cycle("add_ex1", mk(4'b0100, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0));

        // BRZ not taken
        Zflag = 1'b0;
        fetch("brz0", 8'h80);
        expect_cycle("brz0_dec", mk(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0));

        // BRZ taken
        fetch("brz1", 8'h80);
        Zflag = 1'b1;
        expect_cycle("brz1_dec", e_pc_addr);
        Zflag = 1'b0;
        expect_cycle("brz1_br1", mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        expect_cycle("brz1_br2", mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));

        // WR src=R1
        fetch("wr", 8'h64);
        expect_cycle("wr_dec", e_pc_addr);
        expect_cycle("wr_wr1", e_mem_addr_inc);
        expect_cycle("wr_wr2", mk(4'b0000, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 1, 0));

        // NOT src=R2 dest=R3
        fetch("not", 8'h4B);
        expect_cycle("not_dec", mk(4'b1000, 0, 0, 3'd2, 2'd0, 0, 0, 0, 1, 0, 0));

        // RD dest=R1
        fetch("rd", 8'h51);
        expect_cycle("rd_dec", e_pc_addr);
        expect_cycle("rd_rd1", e_mem_addr_inc);
        expect_cycle("rd_rd2", mk(4'b0010, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));

        // BR unconditional, then NOP
        fetch("br", 8'h70);
        expect_cycle("br_dec", e_pc_addr);
        expect_cycle("br_br1", mk(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0));
        expect_cycle("br_br2", mk(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));
        fetch("nop", 8'h00);
        expect_cycle("nop_dec", E_ZERO);

        // Illegal opcode halts until reset
        fetch("ill", 8'hF0);
        expect_cycle("ill_dec", E_ZERO);
        for (int i = 0; i < 20; i++) expect_cycle("halt", e_halt);
        rst = 1'b1;
        it.name = "halt_async_reset";
        it.exp  = E_ZERO;
        exp_q.push_back(it);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_cycle("idle_after_halt", E_ZERO);
        fetch("resume", 8'h00);
        expect_cycle("resume_dec", E_ZERO);

        // Async reset in the middle of S_rd1
        fetch("rdrst", 8'h53);
        expect_cycle("rdrst_dec", e_pc_addr);
        it.name = "rdrst_rd1";
        it.exp  = e_mem_addr_inc;
        exp_q.push_back(it);
        @(negedge clk);
        #2;
        rst = 1'b1;
        it.name = "rdrst_mid_cycle_drop";
        it.exp  = E_ZERO;
        exp_q.push_back(it);
        @(posedge clk);
        #1;
        expect_cycle("rdrst_held", E_ZERO);
        rst = 1'b0;
        instruction = 8'h00;
        expect_cycle("rdrst_idle", E_ZERO);
        fetch("after_rst", 8'h00);
        expect_cycle("after_rst_dec", E_ZERO);
        expect_cycle("after_rst_fet1", e_fet1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
- Multi-cycle FSM that sequences the processing unit.
- Consumes `instruction` (IR contents) and `Zflag`.
- Drives every register-load, PC, bus-mux select and memory-write strobe.
- One instruction executes per 3–5 clocks: fetch, decode, then execute/memory/branch states. Fetch restarts after each instruction.

Parameters:
- word_size, 8, instruction/data width
- op_size, 4, opcode width (instruction[7:4])
- Sel1_size, 3, Bus_1 mux select width
- Sel2_size, 2, Bus_2 mux select width
- state_size, 4, state register width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- instruction  input  word_size  IR contents: [7:4] opcode, [3:2] src, [1:0] dest
- Zflag  input  1  registered ALU zero flag
- Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register load enables
- Load_PC  output  1  PC parallel load
- Inc_PC  output  1  PC increment
- Sel_Bus_1_Mux  output  Sel1_size  0=R0, 1=R1, 2=R2, 3=R3, 4=PC
- Sel_Bus_2_Mux  output  Sel2_size  0=alu_out, 1=Bus_1, 2=mem_word
- Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z  output  1 each  register load enables
- write  output  1  memory write strobe (addr = address reg, data = Bus_1)
- halted  output  1  high while FSM is in S_halt

Behaviour:
- State register: async reset to S_idle. All other logic is combinational from state, instruction and Zflag.
- Output defaults:
  - All strobes are 0 in any state unless listed below.
  - Unlisted selects are 0.
  - In S_idle all outputs are 0, so outputs during and immediately after reset are 0.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8. Opcodes 9–15 are illegal.
- S_idle -> S_fet1 (unconditional, first clock after rst falls).
- S_fet1: Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_fet2.
- S_fet2: Sel2=mem, Load_IR, Inc_PC -> S_dec.
- S_dec, by opcode:
  - NOP -> S_fet1, no strobes.
  - ADD/SUB/AND: Sel1=src, Sel2=Bus_1, Load_Reg_Y -> S_ex1.
  - NOT: Sel1=src, Sel2=alu, Load_Reg_Z, Load_R[dest] -> S_fet1.
  - RD: Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_rd1.
  - WR: Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_wr1.
  - BR: Sel1=PC, Sel2=Bus_1, Load_Add_R -> S_br1.
  - BRZ with Zflag=1: same outputs as BR -> S_br1.
  - BRZ with Zflag=0: Inc_PC only (skips operand byte) -> S_fet1.
  - Illegal opcode -> S_halt.
- S_ex1: Sel1=dest, Sel2=alu, Load_Reg_Z, Load_R[dest] -> S_fet1.
- S_rd1: Sel2=mem, Load_Add_R, Inc_PC -> S_rd2.
- S_rd2: Sel2=mem, Load_R[dest] -> S_fet1.
- S_wr1: Sel2=mem, Load_Add_R, Inc_PC -> S_wr2.
- S_wr2: Sel1=src, write -> S_fet1.
- S_br1: Sel2=mem, Load_Add_R -> S_br2.
- S_br2: Sel2=mem, Load_PC -> S_fet1.
- S_halt: all strobes 0, halted=1. Stays until rst.
- Cycle counts from S_fet1 back to S_fet1:
  - NOP 3; NOT 3; ADD/SUB/AND 4; RD 5; WR 5; BR 5.
  - BRZ 5 when Zflag=1, 3 when Zflag=0.
- Invariants:
  - Exactly one Load_R* is high in any cycle where a register load is asserted.
  - Load_PC and Inc_PC are never high together.
  - write is never high outside S_wr2.
- Unused state encodings (state_size=4) -> S_halt next cycle.
- Reset mid-instruction: async return to S_idle in the same cycle. All strobes drop immediately and nothing partial is committed afterward.
- `instruction` is sampled only in S_dec and the execute states. IR is stable there because Load_IR fires only in S_fet2.

Decomposition:
- Shared package holds:
  - opcode constants
  - state encodings
  - Sel_Bus_1 and Sel_Bus_2 encodings
  - instruction field bit positions
- The processing unit and the ALU import the same package.
- Single module. The combinational output decoder is a natural `always` block, not a separate sub-module.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset. Exactly one S_idle cycle, then S_fet1 with Sel1=4, Sel2=1, Load_Add_R=1.
- instruction=8'h1E (ADD src=R3, dest=R2) -> S_dec: Sel1=3, Load_Reg_Y. Next cycle: Sel1=2, Sel2=0, Load_Reg_Z, Load_R2. Then S_fet1. 4 cycles total.
- instruction=8'h80 (BRZ), Zflag=0 -> S_dec: Inc_PC only, then S_fet1. Repeat with Zflag=1 -> S_br1, then S_br2 with Load_PC=1, Sel2=2.
- instruction=8'h64 (WR src=R1) -> write=1 only in S_wr2, with Sel1=1. Inc_PC pulses exactly once after the fetch (in S_wr1).
- instruction=8'hF0 -> halted=1 and all strobes 0 for 20 cycles. rst pulse -> S_idle, then fetch resumes.
- Assert rst asynchronously mid-S_rd1 -> Load_Add_R and Inc_PC drop before the next clock edge. No Load_R* is asserted afterward until a new fetch.
